reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port successor to the core's integer register file. It is generic in data width, register count and read-port count, and adds the following:
- two write ports with defined priority
- optional write-to-read bypass
- per-register busy scoreboard for multicycle producers (mul/div, loads)
- sequential clear engine that sweeps storage to zero after reset or on request

It sits in the decode/writeback path of the pipelined core, between the decoder and the ALU/forwarding muxes.

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers (>=2; need not be a power of two).
NRD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = register 0 hardwired to zero (reads 0, writes dropped, never busy).
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
Derived: AW = $clog2(NREGS).

Ports:
clk  in  1  clock; all state changes on rising edge.
RST  in  1  asynchronous active-high reset.
RF_ADR  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW].
RF_RS  out  NRD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN].
RF_WA0 / RF_WD0 / RF_EN0  in  AW / XLEN / 1  write port 0 (ALU writeback).
RF_WA1 / RF_WD1 / RF_EN1  in  AW / XLEN / 1  write port 1 (load/multicycle writeback; higher priority).
RF_BUSY_SET  in  1  mark register RF_BUSY_ADR busy at this edge.
RF_BUSY_ADR  in  AW  register to mark busy.
RF_CLR_REQ  in  1  request full clear sweep.
RF_READY  out  1  1 = file in RUN state and usable.
RF_BUSY  out  NREGS  per-register busy bits, registered.

Behaviour:
- FSM states: CLEAR and RUN. A counter clr_idx (AW bits) is used only in CLEAR.
- RST asserted (async) puts the block in the following state:
  - state = CLEAR, clr_idx = 0
  - RF_READY = 0
  - RF_BUSY = all 0
  - storage is not reset directly; the sweep clears it.
- CLEAR: each edge writes 0 to storage[clr_idx] and increments clr_idx. On the edge that clears index NREGS-1, state goes to RUN.
- RF_READY = 1 after exactly NREGS rising edges following RST deassertion.
- In CLEAR:
  - RF_EN0/RF_EN1/RF_BUSY_SET are ignored.
  - all RF_RS outputs are 0.
  - RF_CLR_REQ is ignored (the sweep is not restarted).
- RUN + RF_CLR_REQ: at the next edge, state = CLEAR, clr_idx = 0, RF_BUSY = 0, RF_READY drops. Any writes presented on that edge are dropped.
- RST asserted mid-sweep: the sweep restarts from index 0.
- Reads are combinational, with zero latency. Per port, in priority order:
  1. not READY -> 0
  2. address >= NREGS -> 0
  3. ZERO_REG and address == 0 -> 0
  4. BYPASS and RF_EN1 and RF_WA1 == addr -> RF_WD1
  5. BYPASS and RF_EN0 and RF_WA0 == addr -> RF_WD0
  6. storage[addr]
- Writes commit at the rising edge. A port commits when all of the following hold: RF_ENx, READY, RF_WAx < NREGS, and not (ZERO_REG and RF_WAx == 0).
- Both ports enabled to the same address: port 1 value is stored and port 0 is dropped. Distinct addresses: both commit in the same cycle.
- Scoreboard:
  - Each committed write clears RF_BUSY[RF_WAx].
  - RF_BUSY_SET (in RUN, with an in-range address that is not the ZERO_REG x0) sets RF_BUSY[RF_BUSY_ADR].
  - Set and clear of the same bit on the same edge: set wins, because a new producer was issued.
  - Setting an already-busy bit leaves it 1.
  - RF_BUSY[0] is constant 0 when ZERO_REG = 1.
- RF_BUSY is informational only. Writes and reads are never blocked by busy bits; stalling is the hazard unit's responsibility.

Test Plan:
- Reset/clear: NREGS=32. Deassert RST -> RF_READY=0 for 32 edges, then 1. Read all registers -> 0x00000000. Writes attempted during CLEAR leave storage 0.
- Basic write/read: write x5 = 0xDEADBEEF via port 0 -> next cycle RF_RS port0 (addr 5) = 0xDEADBEEF. Write x0 = 0x1234 -> x0 reads 0.
- Dual write: same cycle, port0 x7 = 0x11 and port1 x7 = 0x22 -> x7 = 0x22. Port0 x3 = 0xA and port1 x4 = 0xB -> both stored.
- Bypass: RF_EN0, RF_WA0 = 9, RF_WD0 = 0x55 with read addr 9 in the same cycle -> RF_RS = 0x55 combinationally. With BYPASS=0 -> old value, then 0x55 the next cycle.
- Scoreboard: BUSY_SET x12 -> RF_BUSY[12] = 1. Port1 writes x12 -> bit clears. BUSY_SET x12 together with port0 write x12 on the same edge -> RF_BUSY[12] stays 1. BUSY_SET x0 -> bit stays 0.
- Clear request mid-run: x2 = 0xFF, RF_BUSY[2] = 1, assert RF_CLR_REQ -> RF_READY = 0 next cycle and RF_BUSY = 0. RST pulsed after 10 sweep cycles -> READY returns 32 edges after deassert and x2 reads 0. Also run NREGS=24, NRD=3: addr 30 reads 0 and a write to addr 30 is dropped.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with dual prioritized writeback, optional
// write-to-read bypass, per-register busy scoreboard and a sequential clear sweep.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RF_ADR,
    output logic [NRD*XLEN-1:0] RF_RS,
    input  logic [AW-1:0]       RF_WA0,
    input  logic [XLEN-1:0]     RF_WD0,
    input  logic                RF_EN0,
    input  logic [AW-1:0]       RF_WA1,
    input  logic [XLEN-1:0]     RF_WD1,
    input  logic                RF_EN1,
    input  logic                RF_BUSY_SET,
    input  logic [AW-1:0]       RF_BUSY_ADR,
    input  logic                RF_CLR_REQ,
    output logic                RF_READY,
    output logic [NREGS-1:0]    RF_BUSY
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    logic              state;
    logic [AW-1:0]     clr_idx;
    logic [XLEN-1:0]   mem [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_nxt;
    logic              ready;
    logic              wr0;
    logic              wr1;
    logic              bset;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic is_x0(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign ready    = (state == ST_RUN);
    assign RF_READY = ready;
    assign RF_BUSY  = busy_q;

    // A clear request wins over everything else on its edge, so writes are gated by it.
    assign wr1  = RF_EN1 && ready && !RF_CLR_REQ && in_range(RF_WA1) && !is_x0(RF_WA1);
    assign wr0  = RF_EN0 && ready && !RF_CLR_REQ && in_range(RF_WA0) && !is_x0(RF_WA0)
                  && !(wr1 && (RF_WA1 == RF_WA0));
    assign bset = RF_BUSY_SET && ready && in_range(RF_BUSY_ADR) && !is_x0(RF_BUSY_ADR);

    always_comb begin
        busy_nxt = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (wr0 && (RF_WA0 == AW'(r))) busy_nxt[r] = 1'b0;
            if (wr1 && (RF_WA1 == AW'(r))) busy_nxt[r] = 1'b0;
            // A newly issued producer outranks the writeback retiring the old one.
            if (bset && (RF_BUSY_ADR == AW'(r))) busy_nxt[r] = 1'b1;
        end
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy_q  <= '0;
        end else if (state == ST_CLEAR) begin
            busy_q <= '0;
            if (clr_idx == LAST) begin
                state   <= ST_RUN;
                clr_idx <= '0;
            end else begin
                clr_idx <= clr_idx + 1'b1;
            end
        end else if (RF_CLR_REQ) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Storage has no reset; the sweep zeroes one entry per edge while not ready.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (!ready) begin
                if (clr_idx == AW'(r)) mem[r] <= '0;
            end else if (wr1 && (RF_WA1 == AW'(r))) begin
                mem[r] <= RF_WD1;
            end else if (wr0 && (RF_WA0 == AW'(r))) begin
                mem[r] <= RF_WD0;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rs;

        assign addr = RF_ADR[g*AW +: AW];

        always_comb begin
            rs = '0;
            if (ready && in_range(addr) && !is_x0(addr)) begin
                if ((BYPASS != 0) && RF_EN1 && (RF_WA1 == addr))
                    rs = RF_WD1;
                else if ((BYPASS != 0) && RF_EN0 && (RF_WA0 == addr))
                    rs = RF_WD0;
                else
                    rs = mem[addr];
            end
        end

        assign RF_RS[g*XLEN +: XLEN] = rs;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build, a no-bypass build sharing the
// same stimulus, and a 24-entry 3-read-port build sharing the write side.
module tb_reg_file_mp;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2*AW-1:0] adr;
    logic [3*AW-1:0] adr2;
    logic [63:0]   rs_a;
    logic [63:0]   rs_b;
    logic [95:0]   rs_c;
    logic [AW-1:0] wa0, wa1, badr;
    logic [31:0]   wd0, wd1;
    logic          en0, en1, bset, clr;
    logic          rdy_a, rdy_b, rdy_c;
    logic [31:0]   busy_a, busy_b;
    logic [23:0]   busy_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_mp u_a (
        .clk(clk), .RST(rst), .RF_ADR(adr), .RF_RS(rs_a),
        .RF_WA0(wa0), .RF_WD0(wd0), .RF_EN0(en0),
        .RF_WA1(wa1), .RF_WD1(wd1), .RF_EN1(en1),
        .RF_BUSY_SET(bset), .RF_BUSY_ADR(badr), .RF_CLR_REQ(clr),
        .RF_READY(rdy_a), .RF_BUSY(busy_a)
    );

    reg_file_mp #(.BYPASS(0)) u_b (
        .clk(clk), .RST(rst), .RF_ADR(adr), .RF_RS(rs_b),
        .RF_WA0(wa0), .RF_WD0(wd0), .RF_EN0(en0),
        .RF_WA1(wa1), .RF_WD1(wd1), .RF_EN1(en1),
        .RF_BUSY_SET(bset), .RF_BUSY_ADR(badr), .RF_CLR_REQ(clr),
        .RF_READY(rdy_b), .RF_BUSY(busy_b)
    );

    reg_file_mp #(.NREGS(24), .NRD(3)) u_c (
        .clk(clk), .RST(rst), .RF_ADR(adr2), .RF_RS(rs_c),
        .RF_WA0(wa0), .RF_WD0(wd0), .RF_EN0(en0),
        .RF_WA1(wa1), .RF_WD1(wd1), .RF_EN1(en1),
        .RF_BUSY_SET(bset), .RF_BUSY_ADR(badr), .RF_CLR_REQ(clr),
        .RF_READY(rdy_c), .RF_BUSY(busy_c)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en0  = 1'b0;
        en1  = 1'b0;
        bset = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        idle();
        adr = '0; adr2 = '0;
        wa0 = '0; wa1 = '0; badr = '0; wd0 = '0; wd1 = '0;
        #12;
        check("rst_ready", 64'(rdy_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);

        // Release reset; writes and busy-set during the sweep must be ignored.
        rst = 1'b0;
        en0 = 1'b1; wa0 = 5'd5; wd0 = 32'h77;
        bset = 1'b1; badr = 5'd6;
        adr = {5'd0, 5'd5};
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 10) check("clear_rs_zero", 64'(rs_a[31:0]), 64'd0);
            if (i == 20) idle();
            if (i == 23) check("c_ready_23", 64'(rdy_c), 64'd0);
            if (i == 24) check("c_ready_24", 64'(rdy_c), 64'd1);
            if (i == 31) check("a_ready_31", 64'(rdy_a), 64'd0);
            if (i == 32) begin
                check("a_ready_32", 64'(rdy_a), 64'd1);
                check("b_ready_32", 64'(rdy_b), 64'd1);
            end
        end
        check("busy_after_clear", 64'(busy_a), 64'd0);
        for (int a = 0; a < 32; a++) begin
            adr = {5'd0, 5'(a)};
            #1;
            check("sweep_read", 64'(rs_a[31:0]), 64'd0);
        end

        // Basic write/read and x0.
        en0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        tick(); idle();
        adr = {5'd0, 5'd5}; #1;
        check("wr_x5", 64'(rs_a[31:0]), 64'hDEADBEEF);
        en0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234;
        adr = {5'd0, 5'd0}; #1;
        check("x0_bypass", 64'(rs_a[31:0]), 64'd0);
        tick(); idle(); #1;
        check("x0_read", 64'(rs_a[31:0]), 64'd0);

        // Dual write: same address, then distinct addresses.
        en0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        en1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        tick(); idle();
        adr = {5'd0, 5'd7}; #1;
        check("dual_same_a", 64'(rs_a[31:0]), 64'h22);
        check("dual_same_b", 64'(rs_b[31:0]), 64'h22);
        en0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA;
        en1 = 1'b1; wa1 = 5'd4; wd1 = 32'hB;
        tick(); idle();
        adr = {5'd4, 5'd3}; #1;
        check("dual_x3", 64'(rs_a[31:0]), 64'hA);
        check("dual_x4", 64'(rs_a[63:32]), 64'hB);

        // Bypass versus no-bypass build.
        en0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
        adr = {5'd0, 5'd9}; #1;
        check("byp_on", 64'(rs_a[31:0]), 64'h55);
        check("byp_off_old", 64'(rs_b[31:0]), 64'd0);
        tick(); idle(); #1;
        check("byp_off_new", 64'(rs_b[31:0]), 64'h55);
        en0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77;
        en1 = 1'b1; wa1 = 5'd9; wd1 = 32'h66;
        #1;
        check("byp_prio", 64'(rs_a[31:0]), 64'h66);
        check("byp_prio_off", 64'(rs_b[31:0]), 64'h55);
        tick(); idle(); #1;
        check("byp_prio_stored", 64'(rs_a[31:0]), 64'h66);

        // Scoreboard.
        bset = 1'b1; badr = 5'd12;
        tick(); idle();
        check("busy_set12", 64'(busy_a), 64'h1000);
        en1 = 1'b1; wa1 = 5'd12; wd1 = 32'h1;
        tick(); idle();
        check("busy_clr12", 64'(busy_a), 64'h0);
        bset = 1'b1; badr = 5'd12;
        en0 = 1'b1; wa0 = 5'd12; wd0 = 32'h2;
        tick(); idle();
        check("busy_set_wins", 64'(busy_a), 64'h1000);
        bset = 1'b1; badr = 5'd0;
        tick(); idle();
        check("busy_x0", 64'(busy_a), 64'h1000);

        // Clear request mid-run, then reset mid-sweep.
        en0 = 1'b1; wa0 = 5'd2; wd0 = 32'hFF;
        bset = 1'b1; badr = 5'd2;
        tick(); idle();
        check("busy_pre_clr", 64'(busy_a), 64'h1004);
        adr = {5'd0, 5'd2}; #1;
        check("x2_pre_clr", 64'(rs_a[31:0]), 64'hFF);
        clr = 1'b1;
        en0 = 1'b1; wa0 = 5'd3; wd0 = 32'h99;
        tick(); idle();
        check("clr_ready", 64'(rdy_a), 64'd0);
        check("clr_busy", 64'(busy_a), 64'd0);
        repeat (10) tick();
        rst = 1'b1; #2; rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31) check("rst2_ready_31", 64'(rdy_a), 64'd0);
            if (i == 32) check("rst2_ready_32", 64'(rdy_a), 64'd1);
        end
        adr = {5'd3, 5'd2}; #1;
        check("x2_after", 64'(rs_a[31:0]), 64'd0);
        check("x3_after", 64'(rs_a[63:32]), 64'd0);

        // Out-of-range address on the 24-entry build.
        en0 = 1'b1; wa0 = 5'd30; wd0 = 32'hAB;
        en1 = 1'b1; wa1 = 5'd23; wd1 = 32'hC3;
        bset = 1'b1; badr = 5'd30;
        adr2 = {5'd30, 5'd23, 5'd5};
        #1;
        check("c_oor_bypass", 64'(rs_c[95:64]), 64'd0);
        check("c_x23_bypass", 64'(rs_c[63:32]), 64'hC3);
        tick(); idle(); #1;
        check("c_oor_read", 64'(rs_c[95:64]), 64'd0);
        check("c_x23_read", 64'(rs_c[63:32]), 64'hC3);
        check("c_x5_read", 64'(rs_c[31:0]), 64'd0);
        check("c_busy_oor", 64'(busy_c), 64'd0);
        check("a_busy30", 64'(busy_a), 64'h4000_0000);
        adr = {5'd0, 5'd30}; #1;
        check("a_x30", 64'(rs_a[31:0]), 64'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
